// File: rtl/lane_balance_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_balance_pkg : shared state type and helpers for lane_balance_sched  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package lane_balance_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACCUM = 3'd1,
      EVAL  = 3'd2,
      REQ   = 3'd3,
      COOL  = 3'd4
   } lbs_state_t;

   // Wide enough for any accumulator width this block can be built with.
   localparam int DIFF_W = 32;

   function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                  input logic [DIFF_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_balance_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_balance_sched_if : sample input and swap req/ack bundle             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface lane_balance_sched_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4,
   parameter int WINDOW     = 8
);
   localparam int SBIT_CNT_B = $clog2(DATA_WIDTH);
   localparam int ACC_W      = $clog2(WINDOW*DATA_WIDTH+1);
   localparam int IDX_W      = $clog2(LANES);

   logic                               en_i;
   logic                               valid_i;
   logic [LANES-1:0][SBIT_CNT_B:0]     lane_sbit_cnt_i;
   logic [ACC_W-1:0]                   threshold_i;
   logic                               swap_ack_i;
   logic                               swap_req_o;
   logic [IDX_W-1:0]                   swap_idx_o;
   logic [ACC_W-1:0]                   max_imb_o;
   logic                               window_done_o;
   logic                               busy_o;

   modport slave (
      input  en_i, valid_i, lane_sbit_cnt_i, threshold_i, swap_ack_i,
      output swap_req_o, swap_idx_o, max_imb_o, window_done_o, busy_o
   );

   modport master (
      output en_i, valid_i, lane_sbit_cnt_i, threshold_i, swap_ack_i,
      input  swap_req_o, swap_idx_o, max_imb_o, window_done_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/lane_balance_sched_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_sbit_accum : per-lane switched-bit accumulators + window counter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lane_sbit_accum #(
   parameter int LANES  = 4,
   parameter int CNT_W  = 6,
   parameter int ACC_W  = 9,
   parameter int WINDOW = 8
) (
   input  wire logic                          clk_i,
   input  wire logic                          rst_i,
   input  wire logic                          clr_i,
   input  wire logic                          add_en_i,
   input  wire logic [LANES-1:0][CNT_W-1:0]   cnt_i,
   output logic      [LANES-1:0][ACC_W-1:0]   acc_o,
   output logic                               done_o
);
   localparam int WCNT_W = $clog2(WINDOW+1);

   logic [LANES-1:0][ACC_W-1:0] acc_q;
   logic [WCNT_W-1:0]           wcnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         acc_q  <= '0;
         wcnt_q <= '0;
      end else if (add_en_i) begin
         for (int l = 0; l < LANES; l++) begin
            acc_q[l] <= acc_q[l] + ACC_W'(cnt_i[l]);
         end
         wcnt_q <= wcnt_q + 1'b1;
      end
   end

   // High while the sample being added is the one that completes the window.
   assign done_o = add_en_i && (wcnt_q == WCNT_W'(WINDOW-1));
   assign acc_o  = acc_q;

endmodule
`default_nettype wire

// File: rtl/lane_balance_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_balance_sched : window-based adjacent-lane imbalance swap scheduler |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lane_balance_sched
   import lane_balance_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4,
   parameter int WINDOW     = 8,
   parameter int COOLDOWN   = 16
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   lane_balance_sched_if.slave bus
);
   localparam int SBIT_CNT_B = $clog2(DATA_WIDTH);
   localparam int ACC_W      = $clog2(WINDOW*DATA_WIDTH+1);
   localparam int IDX_W      = $clog2(LANES);
   localparam int COOL_W     = $clog2(COOLDOWN+1);

   lbs_state_t        state_q;
   logic              swap_req_q;
   logic              window_done_q;
   logic              busy_q;
   logic [IDX_W-1:0]  swap_idx_q;
   logic [ACC_W-1:0]  max_imb_q;
   logic [COOL_W-1:0] cool_q;

   logic [LANES-1:0][ACC_W-1:0] w_acc;
   logic              w_acc_clr;
   logic              w_add_en;
   logic              w_win_full;
   logic [DIFF_W-1:0] w_best;
   logic [IDX_W-1:0]  w_best_idx;
   logic              w_over;
   logic              w_cool_end;

   assign w_add_en   = (state_q == ACCUM) && bus.en_i && bus.valid_i;
   assign w_cool_end = (cool_q == COOL_W'(COOLDOWN-1));
   assign w_over     = w_best > DIFF_W'(bus.threshold_i);
   assign w_acc_clr  = bus.en_i && ((state_q == IDLE)
                                 || (state_q == EVAL && !w_over)
                                 || (state_q == COOL && w_cool_end));

   lane_sbit_accum #(
      .LANES  (LANES),
      .CNT_W  (SBIT_CNT_B+1),
      .ACC_W  (ACC_W),
      .WINDOW (WINDOW)
   ) u_accum (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (w_acc_clr),
      .add_en_i (w_add_en),
      .cnt_i    (bus.lane_sbit_cnt_i),
      .acc_o    (w_acc),
      .done_o   (w_win_full)
   );

   // Strict '>' keeps the lowest pair index on ties.
   always_comb begin
      logic [DIFF_W-1:0] d;
      d          = '0;
      w_best     = abs_diff(DIFF_W'(w_acc[0]), DIFF_W'(w_acc[1]));
      w_best_idx = '0;
      for (int i = 1; i < LANES-1; i++) begin
         d = abs_diff(DIFF_W'(w_acc[i]), DIFF_W'(w_acc[i+1]));
         if (d > w_best) begin
            w_best     = d;
            w_best_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         swap_req_q    <= 1'b0;
         window_done_q <= 1'b0;
         busy_q        <= 1'b0;
         swap_idx_q    <= '0;
         max_imb_q     <= '0;
         cool_q        <= '0;
      end else begin
         window_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.en_i) begin
                  state_q <= ACCUM;
                  busy_q  <= 1'b1;
               end
            end
            ACCUM: begin
               if (!bus.en_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (w_win_full) begin
                  state_q       <= EVAL;
                  window_done_q <= 1'b1;
               end
            end
            EVAL: begin
               if (!bus.en_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  max_imb_q <= ACC_W'(w_best);
                  if (w_over) begin
                     swap_idx_q <= w_best_idx;
                     swap_req_q <= 1'b1;
                     state_q    <= REQ;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            REQ: begin
               // A request is never withdrawn; enable only decides where the ack leads.
               if (bus.swap_ack_i) begin
                  swap_req_q <= 1'b0;
                  cool_q     <= '0;
                  if (bus.en_i) begin
                     state_q <= COOL;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            COOL: begin
               if (!bus.en_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (w_cool_end) begin
                  state_q <= ACCUM;
               end else begin
                  cool_q <= cool_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.swap_req_o    = swap_req_q;
   assign bus.swap_idx_o    = swap_idx_q;
   assign bus.max_imb_o     = max_imb_q;
   assign bus.window_done_o = window_done_q;
   assign bus.busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_balance_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lane_balance_sched : directed + random bench with behavioural model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lane_balance_sched;
   localparam int DATA_WIDTH = 32;
   localparam int LANES      = 4;
   localparam int WINDOW     = 8;
   localparam int COOLDOWN   = 16;
   localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;
   localparam int ACC_W      = $clog2(WINDOW*DATA_WIDTH+1);

   localparam int P_IDLE = 0;
   localparam int P_FILL = 1;
   localparam int P_EVAL = 2;
   localparam int P_REQ  = 3;
   localparam int P_COOL = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lane_balance_sched_if #(.DATA_WIDTH(DATA_WIDTH), .LANES(LANES), .WINDOW(WINDOW)) bus();

   lane_balance_sched #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .WINDOW     (WINDOW),
      .COOLDOWN   (COOLDOWN)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   int s_rst, s_en, s_valid, s_thr, s_ack;
   int s_cnt [LANES];

   int phase;
   int acc [LANES];
   int nsamp;
   int cool_left;
   int e_req, e_idx, e_max, e_done, e_busy;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_window();
      for (int l = 0; l < LANES; l++) acc[l] = 0;
      nsamp = 0;
   endtask

   // Reference: window sums, adjacent |diff| maximum, request/cooldown bookkeeping.
   task automatic model_step();
      int m, k, d;
      if (s_rst != 0) begin
         phase = P_IDLE;
         clear_window();
         cool_left = 0;
         e_max = 0;
         e_idx = 0;
      end else begin
         case (phase)
            P_IDLE: if (s_en != 0) begin
               clear_window();
               phase = P_FILL;
            end
            P_FILL: if (s_en == 0) phase = P_IDLE;
                    else if (s_valid != 0) begin
                       for (int l = 0; l < LANES; l++) acc[l] += s_cnt[l];
                       nsamp++;
                       if (nsamp == WINDOW) phase = P_EVAL;
                    end
            P_EVAL: if (s_en == 0) phase = P_IDLE;
                    else begin
                       m = -1;
                       k = 0;
                       for (int i = 0; i < LANES-1; i++) begin
                          d = acc[i] - acc[i+1];
                          if (d < 0) d = -d;
                          if (d > m) begin
                             m = d;
                             k = i;
                          end
                       end
                       e_max = m;
                       if (m > s_thr) begin
                          e_idx = k;
                          phase = P_REQ;
                       end else begin
                          clear_window();
                          phase = P_FILL;
                       end
                    end
            P_REQ:  if (s_ack != 0) begin
                       if (s_en != 0) begin
                          phase = P_COOL;
                          cool_left = COOLDOWN;
                       end else begin
                          phase = P_IDLE;
                       end
                    end
            P_COOL: if (s_en == 0) phase = P_IDLE;
                    else begin
                       cool_left--;
                       if (cool_left == 0) begin
                          clear_window();
                          phase = P_FILL;
                       end
                    end
            default: phase = P_IDLE;
         endcase
      end
      e_req  = (phase == P_REQ)  ? 1 : 0;
      e_done = (phase == P_EVAL) ? 1 : 0;
      e_busy = (phase != P_IDLE) ? 1 : 0;
   endtask

   task automatic drive();
      rst             = (s_rst != 0);
      bus.en_i        = (s_en != 0);
      bus.valid_i     = (s_valid != 0);
      bus.threshold_i = ACC_W'(s_thr);
      bus.swap_ack_i  = (s_ack != 0);
      for (int l = 0; l < LANES; l++) bus.lane_sbit_cnt_i[l] = CNT_W'(s_cnt[l]);
   endtask

   task automatic compare();
      check("swap_req",    int'(bus.swap_req_o),    e_req);
      check("swap_idx",    int'(bus.swap_idx_o),    e_idx);
      check("max_imb",     int'(bus.max_imb_o),     e_max);
      check("window_done", int'(bus.window_done_o), e_done);
      check("busy",        int'(bus.busy_o),        e_busy);
   endtask

   task automatic tick();
      drive();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic set_cnt(input int a, input int b, input int c, input int d);
      s_cnt[0] = a;
      s_cnt[1] = b;
      s_cnt[2] = c;
      s_cnt[3] = d;
   endtask

   task automatic fill(input int n);
      s_valid = 1;
      repeat (n) tick();
      s_valid = 0;
   endtask

   int n;

   initial begin
      s_rst = 1; s_en = 0; s_valid = 0; s_thr = 0; s_ack = 0;
      set_cnt(0, 0, 0, 0);
      phase = P_IDLE; clear_window(); cool_left = 0;
      e_req = 0; e_idx = 0; e_max = 0; e_done = 0; e_busy = 0;
      tick();
      tick();
      check("rst_busy", int'(bus.busy_o), 0);
      check("rst_max",  int'(bus.max_imb_o), 0);
      check("rst_req",  int'(bus.swap_req_o), 0);

      s_rst = 0; s_en = 1;
      tick();
      check("start_busy", int'(bus.busy_o), 1);

      // balanced lanes
      set_cnt(10, 10, 10, 10); s_thr = 4;
      fill(8);
      check("s1_done", int'(bus.window_done_o), 1);
      tick();
      check("s1_max", int'(bus.max_imb_o), 0);
      check("s1_req", int'(bus.swap_req_o), 0);

      // lane 0 heavy -> request on pair 0, then cooldown
      set_cnt(20, 10, 10, 10); s_thr = 40;
      fill(8);
      tick();
      check("s2_req", int'(bus.swap_req_o), 1);
      check("s2_idx", int'(bus.swap_idx_o), 0);
      check("s2_max", int'(bus.max_imb_o), 80);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("s2_req_hold", int'(bus.swap_req_o), 1);
      end
      s_ack = 1;
      tick();
      check("s2_req_drop", int'(bus.swap_req_o), 0);
      s_ack = 0;
      set_cnt(5, 5, 5, 5); s_valid = 1;
      n = 0;
      while (n < 100 && bus.window_done_o !== 1'b1) begin
         tick();
         n++;
      end
      check("s2_cool_gap", n, COOLDOWN + WINDOW);
      s_valid = 0;
      tick();

      // tie between pairs 0 and 1, then the strict threshold boundary
      set_cnt(10, 30, 10, 10); s_thr = 0;
      fill(8);
      tick();
      check("s3_idx", int'(bus.swap_idx_o), 0);
      check("s3_max", int'(bus.max_imb_o), 160);
      s_ack = 1; tick(); s_ack = 0;
      repeat (COOLDOWN) tick();
      s_thr = 160;
      fill(8);
      tick();
      check("s3_thr_eq_req", int'(bus.swap_req_o), 0);
      check("s3_thr_eq_busy", int'(bus.busy_o), 1);

      // sparse valid; sample in EVAL must be dropped
      set_cnt(3, 3, 3, 3); s_thr = 255;
      n = 0;
      while (n < 100 && bus.window_done_o !== 1'b1) begin
         s_valid = (n % 2 == 0) ? 1 : 0;
         tick();
         n++;
      end
      check("s4_sparse_len", n, 15);
      s_valid = 1; set_cnt(32, 0, 0, 0);
      tick();
      set_cnt(1, 1, 1, 1);
      fill(8);
      tick();
      check("s4_eval_drop", int'(bus.max_imb_o), 0);

      // enable drop in ACCUM and in REQ
      set_cnt(7, 1, 7, 1);
      fill(5);
      s_en = 0;
      tick();
      check("s5_idle_busy", int'(bus.busy_o), 0);
      s_en = 1;
      tick();
      set_cnt(20, 10, 10, 10); s_thr = 40;
      fill(8);
      tick();
      s_en = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("s5_req_hold", int'(bus.swap_req_o), 1);
      end
      s_ack = 1;
      tick();
      check("s5_ack_busy", int'(bus.busy_o), 0);
      check("s5_ack_req",  int'(bus.swap_req_o), 0);
      s_ack = 0; s_en = 1;
      tick();

      // reset during REQ, then stray ack while accumulating
      fill(8);
      tick();
      check("s6_req", int'(bus.swap_req_o), 1);
      s_rst = 1;
      tick();
      check("s6_rst_req",  int'(bus.swap_req_o), 0);
      check("s6_rst_max",  int'(bus.max_imb_o), 0);
      check("s6_rst_busy", int'(bus.busy_o), 0);
      s_rst = 0;
      tick();
      s_ack = 1;
      fill(8);
      check("s6_stray_done", int'(bus.window_done_o), 1);
      tick();
      check("s6_stray_req", int'(bus.swap_req_o), 1);
      s_ack = 0;
      repeat (4) tick();
      s_ack = 1; tick(); s_ack = 0;

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         s_rst   = ($urandom_range(0, 299) == 0) ? 1 : 0;
         s_en    = ($urandom_range(0, 39) != 0) ? 1 : 0;
         s_valid = ($urandom_range(0, 3) != 0) ? 1 : 0;
         s_ack   = ($urandom_range(0, 3) == 0) ? 1 : 0;
         if ($urandom_range(0, 15) == 0) s_thr = $urandom_range(0, 120);
         for (int l = 0; l < LANES; l++) s_cnt[l] = $urandom_range(0, DATA_WIDTH);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
